// File: rtl/iterative_shifter.sv
// iterative_shifter -- multi-cycle shifter resolving BITS_PER_CYCLE shift-amount
// bits per clock. Every operation takes exactly PASSES cycles in SHIFT, so the
// latency does not depend on the shift amount.
//
// Optional feature: define ITERATIVE_SHIFTER_ROTATE_EN to enable ROR on in_op=11.
// Without it, in_op=11 passes the operand through unchanged with the same latency.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   request present           in_ready  request accepted this cycle
//   in_data    operand [N-1:0]           in_shamt  shift amount [L-1:0]
//   in_op      00 SLL, 01 SRL, 10 SRA, 11 ROR / pass-through
//   out_valid  result present (DONE)     out_ready consumer takes result
//   out_data   result [N-1:0]            busy      high outside IDLE
module iterative_shifter #(
  parameter int N              = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_shamt,
  input  logic [1:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 busy
);
  localparam int L      = $clog2(N);
  localparam int PASSES = (L + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   data_q, data_d;
  logic [L-1:0]   shamt_q, shamt_d;
  logic [1:0]     op_q, op_d;
  logic           sign_q, sign_d;
  logic [PW-1:0]  pass_q, pass_d;
  logic [N-1:0]   shifted;

  // One pass of the network: only the shamt bits owned by the current pass
  // are active, applied lowest weight first. Each stage is a constant shift.
  always_comb begin
    shifted = data_q;
    for (int k = 0; k < L; k++) begin
      if ((k / BITS_PER_CYCLE) == int'(pass_q) && shamt_q[k]) begin
        case (op_q)
          2'b00: shifted = shifted << (1 << k);
          2'b01: shifted = shifted >> (1 << k);
          // SRA fills from the sign latched at accept, not the current MSB.
          2'b10: shifted = (shifted >> (1 << k)) |
                           (sign_q ? ~({N{1'b1}} >> (1 << k)) : {N{1'b0}});
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
          2'b11: shifted = (shifted >> (1 << k)) | (shifted << (N - (1 << k)));
`else
          2'b11: shifted = shifted;
`endif
          default: shifted = shifted;
        endcase
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    shamt_d   = shamt_q;
    op_d      = op_q;
    sign_d    = sign_q;
    pass_d    = pass_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      SHIFT: begin
        data_d = shifted;
        if (pass_q == PW'(PASSES - 1)) begin
          pass_d  = '0;
          state_d = DONE;
        end else begin
          pass_d = pass_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Accepting while draining gives back-to-back ops without an IDLE gap.
        in_ready  = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (in_valid && in_ready) begin
      data_d  = in_data;
      shamt_d = in_shamt;
      op_d    = in_op;
      sign_d  = in_data[N-1];
      pass_d  = '0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      pass_q  <= pass_d;
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_iterative_shifter.sv
module tb_iterative_shifter;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  // second instance with BITS_PER_CYCLE=2
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_in_data, b_out_data;
  logic [4:0]  b_in_shamt;
  logic [1:0]  b_in_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iterative_shifter #(.N(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  iterative_shifter #(.N(32), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_shamt(b_in_shamt), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy));

  // Stimulus driver: issue one request from IDLE, return result and latency
  // (edges after the accept edge until out_valid is first seen).
  task automatic do_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                       output logic [31:0] res, output int lat);
    in_data = d; in_shamt = s; in_op = op; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_flags: got v/b/r=%b%b%b want 001", out_valid, busy, in_ready);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 00000000", out_data);
    end
    checks++;
    if ({b_out_valid, b_busy, b_in_ready, b_out_data} !== {3'b001, 32'h0}) begin
      errors++;
      $display("FAIL reset_dut2: got v/b/r=%b%b%b data=%h", b_out_valid, b_busy, b_in_ready, b_out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_ops_b1();
    logic [31:0] d[8], want[8], res;
    logic [4:0]  s[8];
    logic [1:0]  op[8];
    int lat;
    d[0] = 32'h80000000; s[0] = 5'd4;  op[0] = 2'b10; want[0] = 32'hF8000000;
    d[1] = 32'h80000000; s[1] = 5'd4;  op[1] = 2'b01; want[1] = 32'h08000000;
    d[2] = 32'h00000001; s[2] = 5'd31; op[2] = 2'b00; want[2] = 32'h80000000;
    d[3] = 32'h00000001; s[3] = 5'd0;  op[3] = 2'b00; want[3] = 32'h00000001;
    d[4] = 32'h7FFFFFF0; s[4] = 5'd4;  op[4] = 2'b10; want[4] = 32'h07FFFFFF;
    d[5] = 32'h12345678; s[5] = 5'd13; op[5] = 2'b01; want[5] = 32'h000091A2;
    d[6] = 32'h80000001; s[6] = 5'd31; op[6] = 2'b10; want[6] = 32'hFFFFFFFF;
    d[7] = 32'hFFFFFFFF; s[7] = 5'd16; op[7] = 2'b00; want[7] = 32'hFFFF0000;
    for (int i = 0; i < 8; i++) begin
      do_op(d[i], s[i], op[i], res, lat);
      checks++;
      if (res !== want[i]) begin
        errors++;
        $display("FAIL op%0d_data: got %h want %h", i, res, want[i]);
      end
      checks++;
      if (lat != 5) begin
        errors++;
        $display("FAIL op%0d_latency: got %0d want 5", i, lat);
      end
    end
  endtask

  task automatic test_rotate();
    logic [31:0] res, want;
    int lat;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    want = 32'hF0000000;
`else
    want = 32'h0000000F;
`endif
    do_op(32'h0000000F, 5'd4, 2'b11, res, lat);
    checks++;
    if (res !== want || lat != 5) begin
      errors++;
      $display("FAIL rotate_op: got %h lat %0d want %h lat 5", res, lat, want);
    end
  endtask

  task automatic test_b2();
    int lat;
    b_in_data = 32'h12345678; b_in_shamt = 5'd13; b_in_op = 2'b00;
    b_in_valid = 1'b1; b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_in_data = 32'hDEADBEEF; b_in_shamt = 5'd1;
    lat = 0;
    while (!b_out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (b_out_data !== 32'h8ACF0000) begin
      errors++;
      $display("FAIL b2_data: got %h want 8acf0000", b_out_data);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL b2_latency: got %0d want 3", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    in_data = 32'h000000F0; in_shamt = 5'd4; in_op = 2'b01;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, busy, out_data} !== {3'b101, 32'h0000000F}) begin
        errors++;
        $display("FAIL stall%0d: got v/r/b=%b%b%b data=%h want 101 0000000f",
                 c, out_valid, in_ready, busy, out_data);
      end
    end
    in_data = 32'h00000001; in_shamt = 5'd8; in_op = 2'b00;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept: got busy/valid=%b%b want 10", busy, out_valid);
    end
    // inputs change mid-operation; result must not move
    in_valid = 1'b0; in_data = 32'hDEADBEEF; in_shamt = 5'd3; in_op = 2'b10;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (out_data !== 32'h00000100 || lat != 5) begin
      errors++;
      $display("FAIL b2b_result: got %h lat %0d want 00000100 lat 5", out_data, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic seen;
    in_data = 32'h80000000; in_shamt = 5'd4; in_op = 2'b10;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b010 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL abort_state: got b/r/v=%b%b%b data=%h want 010 00000000",
               busy, in_ready, out_valid, out_data);
    end
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_valid: got out_valid seen=%b want 0", seen);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_op = '0; b_out_ready = 1'b0;
    test_reset();
    test_ops_b1();
    test_rotate();
    test_b2();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iterative_shifter.md
ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 Parameter N, default 32, meaning operand width; SHALL be a power of two, 8 to 64.
REQ-002 Parameter BITS_PER_CYCLE, default 1, meaning shamt bits resolved per cycle; SHALL be 1 to $clog2(N).
REQ-003 Derived constants: L = $clog2(N); PASSES = ceil(L / BITS_PER_CYCLE).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 in_data  input  N  operand.
REQ-009 in_shamt  input  L  shift amount, 0 to N-1.
REQ-010 in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 out_data  output  N  result.
REQ-014 busy  output  1  high in any state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-016 Handshake: request accepted on rising edge where in_valid && in_ready; result transferred where out_valid && out_ready.
REQ-017 in_ready SHALL be 1 in IDLE, equal out_ready in DONE, 0 in SHIFT.
REQ-018 On accept: latch in_data into working register, latch in_shamt, in_op, and sign = in_data[N-1]; clear pass counter; go to SHIFT.
REQ-019 In SHIFT, pass p (0..PASSES-1) SHALL apply, for each k in [p*B, p*B+B-1] with k < L and shamt[k]=1, a shift by 2^k, lower k first.
REQ-020 Fill: SLL zeros into LSBs; SRL zeros into MSBs; SRA latched sign into MSBs; ROR bits leaving LSB re-enter at MSB.
REQ-021 After pass PASSES-1, go to DONE; out_valid SHALL be 1 exactly while in DONE.
REQ-022 Latency SHALL be fixed: accept at edge t, out_valid first high after edge t+PASSES, independent of shamt (shamt=0 included).
REQ-023 out_data SHALL equal the working register and SHALL hold stable while out_valid && !out_ready.
REQ-024 DONE with out_ready=1 and in_valid=0: go to IDLE.
REQ-025 DONE with out_ready=1 and in_valid=1: transfer result and accept new request on the same edge, go directly to SHIFT (one result per PASSES+1 cycles sustained).
REQ-026 in_* inputs SHALL be ignored when not accepted; changes during SHIFT SHALL not affect the result.
REQ-027 Result SHALL equal the single-cycle reference: SLL in<<shamt; SRL in>>shamt; SRA $signed(in)>>>shamt; ROR rotate right by shamt.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, out_valid=0, out_data=0, busy=0, pass counter=0, latched shamt/op/sign=0; in_ready=1 the cycle after.
REQ-029 Reset in SHIFT or DONE SHALL abort the operation; the aborted result SHALL never appear on out_valid.
REQ-030 rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-031 Macro ITERATIVE_SHIFTER_ROTATE_EN: when defined, in_op=11 SHALL perform ROR per REQ-020.
REQ-032 When not defined, in_op=11 SHALL return the operand unchanged with the same fixed latency; no rotate logic SHALL be synthesised.

Verification (N=32 unless stated)
REQ-033 B=1, in_data=0x80000000, shamt=4, op=SRA -> out_data=0xF8000000, out_valid first high 5 cycles after accept.
REQ-034 B=1, same operand op=SRL -> 0x08000000; op=SLL, in_data=0x00000001, shamt=31 -> 0x80000000; shamt=0 -> 0x00000001 still after 5 cycles.
REQ-035 B=2 (PASSES=3), in_data=0x12345678, shamt=13, op=SLL -> 0x8ACF0000 after 3 cycles.
REQ-036 Backpressure: out_ready=0 for 3 cycles in DONE -> out_data/out_valid stable, in_ready=0; then out_ready=1 with in_valid=1 -> result transferred and next request accepted same edge, busy stays 1.
REQ-037 Reset asserted during pass 2 of a 5-pass op -> next cycle busy=0, in_ready=1, out_valid stays 0 through 10 further cycles.
REQ-038 in_data=0x0000000F, shamt=4, op=11 -> 0xF0000000 with ITERATIVE_SHIFTER_ROTATE_EN defined, 0x0000000F without.
